// File: rtl/gray_pkg.sv
// gray_pkg
// Shared types and helpers for the Gray-code step decoder.
//   step_e   : step classification carried on step_out
//   gray2bin : Gray-to-binary conversion at the default width
package gray_pkg;

    localparam int GRAY_W = 8;

    typedef enum logic [1:0] {
        STEP_NONE = 2'b00,
        STEP_UP   = 2'b01,
        STEP_DOWN = 2'b10,
        STEP_JUMP = 2'b11
    } step_e;

    // bin[i] is the XOR of all Gray bits from the MSB down to bit i.
    function automatic logic [GRAY_W-1:0] gray2bin(input logic [GRAY_W-1:0] gray);
        logic [GRAY_W-1:0] bin;
        bin[GRAY_W-1] = gray[GRAY_W-1];
        for (int i = GRAY_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray_step_decoder_gray_to_binary.sv
// gray_to_binary
// Purely combinational Gray-to-binary converter of arbitrary width.
// Ports:
//   gray_in  [WIDTH-1:0]  Gray-coded value
//   bin_out  [WIDTH-1:0]  binary value
module gray_to_binary #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] gray_in,
    output logic [WIDTH-1:0] bin_out
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin_out[i] = ^gray_in[WIDTH-1:i];
    end

endmodule

// File: rtl/gray_step_decoder.sv
// gray_step_decoder
// Two-stage valid/ready pipeline that decodes Gray position samples,
// classifies the step from the previous sample and counts illegal jumps.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   gray_in, in_valid     input sample and its valid
//   in_ready              input may be accepted this cycle
//   bin_out, step_out     decoded position and step class (step_e)
//   out_valid, out_ready  output handshake
//   err_pulse             one-cycle strobe when a JUMP result is loaded
//   err_count             saturating JUMP counter
//   clear_err             synchronous clear of err_count
module gray_step_decoder
    import gray_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] bin_out,
    output logic [1:0]       step_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    input  logic             clear_err
);

    localparam logic [ERR_W-1:0] ERR_MAX = '1;
    localparam logic [WIDTH-1:0] DIFF_UP = WIDTH'(1);
    localparam logic [WIDTH-1:0] DIFF_DN = '1;

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_gray;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_bin_out;
    step_e            r_step_out;
    logic [WIDTH-1:0] r_prev_bin;
    logic             r_prev_valid;
    logic             r_err_pulse;
    logic [ERR_W-1:0] r_err_count;

    logic             w_s1_adv;
    logic             w_load;
    logic             w_jump;
    logic [WIDTH-1:0] w_bin;
    logic [WIDTH-1:0] w_diff;
    step_e            w_step;

    // Stage 2 can take a new value when it is empty or being drained.
    assign w_s1_adv = !r_out_valid || out_ready;
    assign in_ready = !r_s1_valid || w_s1_adv;
    assign w_load   = r_s1_valid && w_s1_adv;
    assign w_jump   = (w_step == STEP_JUMP);

    gray_to_binary #(.WIDTH(WIDTH)) u_g2b (
        .gray_in (r_s1_gray),
        .bin_out (w_bin)
    );

    // Modular difference makes the 2^WIDTH-1 <-> 0 wrap count as a single step.
    assign w_diff = w_bin - r_prev_bin;

    always_comb begin
        w_step = STEP_JUMP;
        if (!r_prev_valid || (w_diff == '0)) begin
            w_step = STEP_NONE;
        end else if (w_diff == DIFF_UP) begin
            w_step = STEP_UP;
        end else if (w_diff == DIFF_DN) begin
            w_step = STEP_DOWN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid   <= 1'b0;
            r_s1_gray    <= '0;
            r_out_valid  <= 1'b0;
            r_bin_out    <= '0;
            r_step_out   <= STEP_NONE;
            r_prev_bin   <= '0;
            r_prev_valid <= 1'b0;
            r_err_pulse  <= 1'b0;
            r_err_count  <= '0;
        end else begin
            if (in_ready) begin
                r_s1_valid <= in_valid;
                // Only capture data on a real transfer so idle-cycle X never enters.
                if (in_valid) begin
                    r_s1_gray <= gray_in;
                end
            end

            if (w_s1_adv) begin
                r_out_valid <= r_s1_valid;
            end

            if (w_load) begin
                r_bin_out    <= w_bin;
                r_step_out   <= w_step;
                r_prev_bin   <= w_bin;
                r_prev_valid <= 1'b1;
            end

            r_err_pulse <= w_load && w_jump;

            // Clear takes priority, then a same-cycle JUMP counts from zero.
            if (clear_err) begin
                r_err_count <= (w_load && w_jump) ? ERR_W'(1) : '0;
            end else if (w_load && w_jump && (r_err_count != ERR_MAX)) begin
                r_err_count <= r_err_count + ERR_W'(1);
            end
        end
    end

    assign bin_out   = r_bin_out;
    assign step_out  = r_step_out;
    assign out_valid = r_out_valid;
    assign err_pulse = r_err_pulse;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_gray_step_decoder.sv
module tb_gray_step_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] gray_in = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] bin_out;
    logic [1:0] step_out;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       err_pulse;
    logic [7:0] err_count;
    logic       clear_err = 1'b0;

    always #5 clk = ~clk;

    gray_step_decoder #(.WIDTH(8), .ERR_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .gray_in   (gray_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bin_out   (bin_out),
        .step_out  (step_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .clear_err (clear_err)
    );

    // Reference model: queue of results in flight, each tagged with the
    // edge index at which it was accepted.
    typedef struct {
        int bin;
        int step;
        int acc;
    } rec_t;

    rec_t q[$];
    int   now = 0;
    int   errors = 0;
    int   checks = 0;
    bit   m_init = 0;
    bit   head_pres = 0;
    int   m_prev = 0;
    bit   m_prev_v = 0;
    int   m_errc = 0;
    bit   m_errp = 0;
    bit   last_acc = 0;

    // Decode by searching for the integer whose Gray code matches.
    function automatic int g2b_ref(int g);
        for (int n = 0; n < 256; n++) begin
            if (((n ^ (n >> 1)) & 255) == g) return n;
        end
        return -1;
    endfunction

    function automatic int b2g(int b);
        return (b ^ (b >> 1)) & 255;
    endfunction

    function automatic bit ov_exp();
        return (q.size() > 0) && (q[0].acc < now);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h (edge %0d)", tag, obs, exp, now);
        end
    endtask

    task automatic step(bit iv, int g, bit ordy, bit clr, bit rst = 1'b1);
        bit ir, pop, acc, jump;
        int b, d, st;
        in_valid  = iv;
        gray_in   = iv ? 8'(g) : 8'bx;
        out_ready = ordy;
        clear_err = clr;
        rst_n     = rst;
        #1;
        ir = (q.size() < 2) || (ordy && ov_exp());
        if (m_init) chk("in_ready", {31'b0, in_ready}, {31'b0, ir});
        pop = rst && ov_exp() && ordy;
        acc = rst && iv && ir;
        @(posedge clk);
        #1;
        now++;
        if (!rst) begin
            q.delete();
            m_prev_v  = 0;
            m_errc    = 0;
            m_errp    = 0;
            head_pres = 0;
            m_init    = 1;
            last_acc  = 0;
        end else begin
            if (pop) begin
                void'(q.pop_front());
                head_pres = 0;
            end
            if (acc) begin
                b  = g2b_ref(g);
                d  = (b - m_prev + 256) % 256;
                st = (!m_prev_v || d == 0) ? 0 : (d == 1) ? 1 : (d == 255) ? 2 : 3;
                q.push_back(rec_t'{b, st, now});
                m_prev   = b;
                m_prev_v = 1;
            end
            last_acc = acc;
            if (ov_exp() && !head_pres) begin
                head_pres = 1;
                jump   = (q[0].step == 3);
                m_errc = clr ? (jump ? 1 : 0) : ((jump && m_errc < 255) ? m_errc + 1 : m_errc);
                m_errp = jump;
            end else begin
                m_errc = clr ? 0 : m_errc;
                m_errp = 0;
            end
        end
        if (m_init) begin
            chk("out_valid", {31'b0, out_valid}, {31'b0, ov_exp()});
            if (ov_exp()) begin
                chk("bin_out", {24'b0, bin_out}, q[0].bin);
                chk("step_out", {30'b0, step_out}, q[0].step);
            end
            chk("err_pulse", {31'b0, err_pulse}, {31'b0, m_errp});
            chk("err_count", {24'b0, err_count}, m_errc);
        end
    endtask

    task automatic send(int g, bit ordy, bit clr);
        int n = 0;
        do begin
            step(1'b1, g, ordy, clr);
            n++;
        end while (!last_acc && n < 50);
        if (!last_acc) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(int n, bit ordy);
        repeat (n) step(1'b0, 0, ordy, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        bit hold;
        int hg, rb, g;
        bit iv;

        do_reset();
        chk("rst_bin_out", {24'b0, bin_out}, 32'd0);
        chk("rst_step_out", {30'b0, step_out}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

        // Basic stream: 0,1,2,3 with UP steps
        send(8'h00, 1, 0);
        chk("lat_edge1", {31'b0, out_valid}, 32'd0);
        send(8'h01, 1, 0);
        chk("lat_edge2", {31'b0, out_valid}, 32'd1);
        send(8'h03, 1, 0);
        send(8'h02, 1, 0);
        idle(3, 1);
        chk("stream_err", {24'b0, err_count}, 32'd0);

        // Wrap up and down
        do_reset();
        send(8'h80, 1, 0);
        send(8'h00, 1, 0);
        send(8'h80, 1, 0);
        idle(3, 1);
        chk("wrap_err", {24'b0, err_count}, 32'd0);

        // Jump 1 -> 5
        do_reset();
        send(8'h01, 1, 0);
        send(8'h07, 1, 0);
        idle(1, 1);
        chk("jump_bin", {24'b0, bin_out}, 32'd5);
        chk("jump_step", {30'b0, step_out}, 32'd3);
        idle(2, 1);
        chk("jump_cnt", {24'b0, err_count}, 32'd1);

        // Backpressure: two accepts, then stalled, then release
        send(8'h01, 0, 0);
        send(8'h03, 0, 0);
        step(1'b1, 8'h02, 0, 0);
        chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
        step(1'b1, 8'h02, 0, 0);
        send(8'h02, 1, 0);
        idle(3, 1);

        // Saturation and clear
        do_reset();
        for (int i = 0; i < 261; i++) send((i % 2) ? b2g(128) : 0, 1, 0);
        idle(2, 1);
        chk("sat_cnt", {24'b0, err_count}, 32'd255);
        send(b2g(128), 1, 0);
        step(1'b0, 0, 1, 1);
        chk("clr_with_jump", {24'b0, err_count}, 32'd1);
        step(1'b0, 0, 1, 1);
        chk("clr_alone", {24'b0, err_count}, 32'd0);

        // Randomized traffic with valid-hold under backpressure
        hold = 0;
        hg   = 0;
        rb   = 0;
        for (int i = 0; i < 400; i++) begin
            if (hold) begin
                iv = 1;
                g  = hg;
            end else begin
                iv = ($urandom % 4) != 0;
                case ($urandom % 4)
                    0: rb = (rb + 1) % 256;
                    1: rb = (rb + 255) % 256;
                    2: rb = rb;
                    default: rb = $urandom % 256;
                endcase
                g = b2g(rb);
            end
            step(iv, g, ($urandom % 4) != 0, ($urandom % 50) == 0);
            hold = iv && !last_acc;
            hg   = g;
        end

        // Mid-stream reset with both stages full
        idle(4, 1);
        send(b2g(10), 0, 0);
        send(b2g(20), 0, 0);
        step(1'b0, 0, 0, 0, 0);
        chk("mrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("mrst_err", {24'b0, err_count}, 32'd0);
        chk("mrst_in_ready", {31'b0, in_ready}, 32'd1);
        send(8'h05, 1, 0);
        idle(1, 1);
        chk("mrst_bin", {24'b0, bin_out}, 32'd6);
        chk("mrst_step", {30'b0, step_out}, 32'd0);
        idle(2, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gray_step_decoder.md
Name: gray_step_decoder

Overview:
- Downstream consumer of the binary-to-Gray stage. Accepts a stream of WIDTH-bit Gray-coded position samples over a valid/ready handshake.
- Decodes each sample to binary and classifies the step from the previous sample as none, up, down or jump.
- Counts illegal multi-count jumps.
- Feeds the position/step result downstream through a 2-stage registered pipeline with backpressure.

Parameters:
- WIDTH, 8, bit width of Gray input and binary output.
- ERR_W, 8, width of the saturating jump-error counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- gray_in  input  WIDTH  Gray-coded sample
- in_valid  input  1  gray_in valid
- in_ready  output  1  block can accept gray_in this cycle
- bin_out  output  WIDTH  decoded binary value
- step_out  output  2  00 NONE, 01 UP, 10 DOWN, 11 JUMP
- out_valid  output  1  bin_out/step_out valid
- out_ready  input  1  downstream accepts output
- err_pulse  output  1  one-cycle strobe on a JUMP result
- err_count  output  ERR_W  saturating count of JUMP results
- clear_err  input  1  synchronous clear of err_count

Behaviour:
- Reset (rst_n=0 at a clk edge), all registers cleared:
  - out_valid=0, bin_out=0, step_out=00, err_pulse=0, err_count=0.
  - Internal s1_valid=0, prev_valid=0.
  - in_ready=1 the cycle after reset.
- Reset mid-operation discards all in-flight samples. No partial output.
- Handshake:
  - Transfer in when in_valid && in_ready.
  - Transfer out when out_valid && out_ready.
  - Data and valid must hold stable while valid && !ready. Same rule on both sides.
- Stage 1:
  - Registers gray_in.
  - s1 advances when !out_valid || out_ready.
  - in_ready = !s1_valid || (s1 advances). Combinational from out_ready; no combinational path from in_valid.
- Stage 2:
  - Computes bin = gray2bin(s1_gray), where bin[i] = XOR of gray[WIDTH-1:i].
  - Registers bin_out and step_out when s1_valid and s1 advances.
- Latency and throughput: a sample accepted at edge N appears with out_valid=1 after edge N+1. Full throughput of 1 sample/cycle when out_ready=1.
- Step classification uses diff = (bin - prev_bin) mod 2^WIDTH:
  - prev_valid=0 -> NONE (first sample after reset).
  - diff==0 -> NONE.
  - diff==1 -> UP, including wrap from 2^WIDTH-1 to 0.
  - diff==2^WIDTH-1 -> DOWN, including wrap from 0 to 2^WIDTH-1.
  - anything else -> JUMP.
- On every stage-2 load: prev_bin <= bin, prev_valid <= 1.
- Stall: while out_valid && !out_ready, stage 2 holds its values. Stage 1 holds if full. in_ready=0 when both stages are full.
- Error strobe and counter:
  - err_pulse=1 for exactly the one cycle after a JUMP result is loaded into stage 2. It is not repeated while stalled.
  - err_count increments on the same load event and saturates at 2^ERR_W-1.
- clear_err:
  - Sets err_count to 0.
  - If a JUMP load occurs in the same cycle, err_count becomes 1 (clear first, then count).
- Unknown/X on gray_in while in_valid=0 must not propagate to outputs.

Decomposition:
- Package gray_pkg contains:
  - step_e enum {STEP_NONE=2'b00, STEP_UP=2'b01, STEP_DOWN=2'b10, STEP_JUMP=2'b11}
  - automatic function gray2bin parameterised by WIDTH via a localparam default of 8
- One combinational sub-module, gray_to_binary (WIDTH parameter; gray_in in, bin_out out), instantiated in stage 2.
- Pipeline control, classification and error counter stay in gray_step_decoder.

Test Plan:
- Reset then stream, out_ready=1, gray 0x00, 0x01, 0x03, 0x02 back-to-back:
  - bin_out 0,1,2,3.
  - step_out NONE, UP, UP, UP.
  - out_valid 2 cycles after first accept; one result per cycle.
  - err_count=0.
- Wrap up/down: gray 0x80 (255), 0x00 (0), 0x80 (255):
  - step NONE, UP, DOWN.
  - err_pulse never asserts.
- Jump: gray 0x01 (1) then 0x07 (5):
  - second result bin_out=5, step JUMP.
  - err_pulse high exactly 1 cycle; err_count=1.
- Backpressure: out_ready=0 for 4 cycles while in_valid=1 streaming 0x01, 0x03, 0x02:
  - in_ready drops to 0 after 2 accepts.
  - outputs hold stable.
  - err_pulse does not repeat.
  - on release, all 3 values emerge in order with no loss or duplication.
- Saturation/clear: force 260 JUMPs with ERR_W=8:
  - err_count sticks at 255.
  - clear_err concurrent with a JUMP load -> err_count=1.
  - clear_err alone -> 0.
- Mid-stream reset: rst_n=0 for 1 cycle with both stages full:
  - next cycle out_valid=0, err_count=0, in_ready=1.
  - the next sample gray 0x05 (6) yields step NONE.
